// File: rtl/rat_pkg.sv
// Shared RAT CPU definitions: program ROM geometry and the fetch-port grant states.
package rat_pkg;
    localparam int RAT_ADDR_W  = 10;
    localparam int RAT_INSTR_W = 18;

    // Who owns the ROM output word in the following cycle
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        DBG_RD = 2'd2
    } grant_t;
endpackage

// File: rtl/prog_fetch_ctrl_if.sv
// Fetch, ROM and debug read-back signals of the program fetch controller.
interface prog_fetch_ctrl_if;
    import rat_pkg::*;

    logic                   FETCH_EN;
    logic                   PC_LD;
    logic [RAT_ADDR_W-1:0]  PC_LD_ADDR;
    logic [RAT_ADDR_W-1:0]  ROM_ADDR;
    logic [RAT_INSTR_W-1:0] ROM_DATA;
    logic [RAT_INSTR_W-1:0] IR;
    logic                   IR_VALID;
    logic [RAT_ADDR_W-1:0]  PC;
    logic                   DBG_REQ;
    logic [RAT_ADDR_W-1:0]  DBG_ADDR;
    logic                   DBG_ACK;
    logic [RAT_INSTR_W-1:0] DBG_DATA;

    // Environment side: CPU control unit, program ROM and debug requester
    modport master (
        output FETCH_EN, PC_LD, PC_LD_ADDR, ROM_DATA, DBG_REQ, DBG_ADDR,
        input  ROM_ADDR, IR, IR_VALID, PC, DBG_ACK, DBG_DATA
    );

    modport slave (
        input  FETCH_EN, PC_LD, PC_LD_ADDR, ROM_DATA, DBG_REQ, DBG_ADDR,
        output ROM_ADDR, IR, IR_VALID, PC, DBG_ACK, DBG_DATA
    );
endinterface

// File: rtl/prog_fetch_ctrl.sv
// Instruction-fetch sequencer owning the PC, sharing the single ROM read port
// with a debug requester under a starvation-bounded priority scheme.
module prog_fetch_ctrl
    import rat_pkg::*;
#(
    parameter int                    ADDR_W       = RAT_ADDR_W,
    parameter int                    INSTR_W      = RAT_INSTR_W,
    parameter logic [ADDR_W-1:0]     RESET_ADDR   = 10'h000,
    parameter int                    DBG_MAX_WAIT = 15
) (
    input  logic             CLK,
    input  logic             RST,
    prog_fetch_ctrl_if.slave bus
);
    localparam logic [7:0] C_MAX_WAIT = 8'(DBG_MAX_WAIT);

    grant_t             r_state;
    logic [ADDR_W-1:0]  r_fa;
    logic [ADDR_W-1:0]  r_fetch_addr;
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_ir;
    logic [INSTR_W-1:0] r_dbg_data;
    logic [7:0]         r_starve;

    logic w_dbg_pending;
    logic w_grant_dbg;
    logic w_grant_cpu;
    logic w_cpu_land;
    logic w_dbg_land;

    // Arbitration; no pending state during the ack cycle stops a same-request regrant
    always_comb begin
        w_dbg_pending = bus.DBG_REQ && (r_state != DBG_RD);
        w_grant_dbg   = w_dbg_pending &&
                        ((r_starve == C_MAX_WAIT) || !bus.FETCH_EN || bus.PC_LD);
        w_grant_cpu   = !w_grant_dbg && bus.FETCH_EN && !bus.PC_LD;
        w_cpu_land    = (r_state == CPU_RD);
        w_dbg_land    = (r_state == DBG_RD);
    end

    assign bus.ROM_ADDR = w_grant_dbg ? bus.DBG_ADDR : r_fa;
    assign bus.IR_VALID = w_cpu_land;
    assign bus.IR       = w_cpu_land ? bus.ROM_DATA : r_ir;
    assign bus.PC       = w_cpu_land ? r_fetch_addr : r_pc;
    assign bus.DBG_ACK  = w_dbg_land;
    assign bus.DBG_DATA = w_dbg_land ? bus.ROM_DATA : r_dbg_data;

    // Grant FSM, fetch address, hold registers and starvation counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= IDLE;
            r_fa         <= RESET_ADDR;
            r_fetch_addr <= '0;
            r_pc         <= '0;
            r_ir         <= '0;
            r_dbg_data   <= '0;
            r_starve     <= 8'd0;
        end else begin
            if (w_grant_dbg) begin
                r_state <= DBG_RD;
            end else if (w_grant_cpu) begin
                r_state <= CPU_RD;
            end else begin
                r_state <= IDLE;
            end

            if (w_grant_cpu) begin
                r_fetch_addr <= r_fa;
            end

            // A redirect always loads FA, even when debug took the slot
            if (bus.PC_LD) begin
                r_fa <= bus.PC_LD_ADDR;
            end else if (w_grant_cpu) begin
                r_fa <= r_fa + ADDR_W'(1);
            end

            if (w_cpu_land) begin
                r_ir <= bus.ROM_DATA;
                r_pc <= r_fetch_addr;
            end

            if (w_dbg_land) begin
                r_dbg_data <= bus.ROM_DATA;
            end

            if (w_grant_dbg || !bus.DBG_REQ) begin
                r_starve <= 8'd0;
            end else if (w_dbg_pending && (r_starve != C_MAX_WAIT)) begin
                r_starve <= r_starve + 8'd1;
            end
        end
    end
endmodule

// File: doc/prog_fetch_ctrl.md
Name: prog_fetch_ctrl

Overview:
Instruction-fetch sequencer and ROM-port arbiter for the RAT program ROM, which has a synchronous read with 18-bit data, a 10-bit address and 1-cycle latency. It owns the program counter and drives the ROM address. It hands fetched instructions to the CPU control unit with a valid pulse. It also shares the single ROM read port with a debug/UART read-back requester, using a starvation-bounded priority scheme.

Parameters:
ADDR_W, 10, ROM address width.
INSTR_W, 18, instruction width.
RESET_ADDR, 10'h000, fetch address after reset.
DBG_MAX_WAIT, 15, max cycles a pending debug read may be blocked by CPU fetches (range 1..255).

Ports:
CLK  in  1  single system clock; all state updates on posedge.
RST  in  1  synchronous, active-high reset.
FETCH_EN  in  1  CPU requests a fetch this cycle (low = CPU stalled).
PC_LD  in  1  redirect: load fetch address from PC_LD_ADDR.
PC_LD_ADDR  in  ADDR_W  redirect target.
ROM_ADDR  out  ADDR_W  address to the program ROM.
ROM_DATA  in  INSTR_W  ROM registered output; holds the word for the address presented last cycle.
IR  out  INSTR_W  last valid fetched instruction.
IR_VALID  out  1  one-cycle pulse: IR holds a newly fetched instruction.
PC  out  ADDR_W  address of the instruction in IR.
DBG_REQ  in  1  debug read request; level signal, held until DBG_ACK.
DBG_ADDR  in  ADDR_W  debug read address; stable while DBG_REQ is high.
DBG_ACK  out  1  one-cycle pulse: DBG_DATA is valid.
DBG_DATA  out  INSTR_W  debug read data; held until the next ack.

Behaviour:
Reset (RST=1 at a posedge):
- FA (fetch address register) <= RESET_ADDR.
- IR, PC, DBG_DATA <= 0.
- IR_VALID, DBG_ACK <= 0.
- starve_cnt <= 0; grant state <= IDLE.
- Any in-flight fetch or debug read is dropped with no ACK and no VALID.
- RST overrides all other inputs.

Grant FSM:
- Grant states are IDLE, CPU_RD and DBG_RD. The state records who owns the ROM output in the next cycle.
- dbg_pending = DBG_REQ & (state != DBG_RD). This prevents a regrant during the ack cycle.

Per-cycle arbitration, in priority order:
1. If dbg_pending and (starve_cnt == DBG_MAX_WAIT, or FETCH_EN = 0, or PC_LD = 1): grant debug.
   - ROM_ADDR = DBG_ADDR; next state DBG_RD.
2. Else if FETCH_EN = 1 and PC_LD = 0: grant CPU.
   - ROM_ADDR = FA; next state CPU_RD.
3. Else: no grant.
   - ROM_ADDR = FA; next state IDLE.

FA update:
- PC_LD = 1: FA <= PC_LD_ADDR. No CPU fetch is issued that cycle; the slot is free for debug.
- CPU grant without PC_LD: FA <= FA + 1, modulo 2^ADDR_W (0x3FF wraps to 0x000).
- Debug grant or idle: FA holds. No address is ever skipped.

Cycle after a CPU grant (state CPU_RD):
- IR = ROM_DATA, PC = fetched address, IR_VALID = 1.
- Latency is one cycle from ROM_ADDR to IR_VALID.
- IR/PC are presented from ROM_DATA combinationally in that cycle and captured into hold registers. They stay stable until the next IR_VALID.

Cycle after a debug grant (state DBG_RD):
- DBG_ACK = 1, DBG_DATA = ROM_DATA (registered hold thereafter).
- IR_VALID = 0; IR and PC are unchanged.
- If DBG_REQ is still high in the cycle after the ACK, it is a new request.

starve_cnt:
- Increments, saturating at DBG_MAX_WAIT, in every cycle with dbg_pending = 1 and no debug grant.
- Clears on a debug grant or when DBG_REQ = 0.
- Guarantees a debug grant within DBG_MAX_WAIT + 1 cycles of request. Each stolen slot costs the CPU exactly one IR_VALID gap.

Other rules:
- Simultaneous PC_LD and debug pending: debug takes the slot and FA is still loaded.
- PC_LD while FETCH_EN = 0: FA is loaded and the next fetch is issued from the target.

Decomposition:
- Shared package rat_pkg holds:
  - RAT_ADDR_W = 10 and RAT_INSTR_W = 18.
  - typedef enum grant_t {IDLE, CPU_RD, DBG_RD}.
- Single module; the starvation counter and FSM are small enough to stay inline. No sub-module.

Test Plan:
- Sequential fetch: ROM[i] = 0x100 + i; release RST, hold FETCH_EN = 1 for 4 cycles -> IR_VALID from the 2nd cycle onward, IR = 0x100, 0x101, 0x102 and PC = 0, 1, 2 on consecutive cycles.
- Branch: PC_LD = 1 with PC_LD_ADDR = 0x200 at cycle t, FETCH_EN = 1 throughout -> IR_VALID = 0 at t+1; at t+2 IR = ROM[0x200], PC = 0x200; at t+3 PC = 0x201.
- Wrap: PC_LD to 0x3FE, then fetch 3 times -> PC sequence 0x3FE, 0x3FF, 0x000 with no gap.
- Stalled debug read: FETCH_EN = 0, DBG_REQ = 1 with DBG_ADDR = 0x055 -> DBG_ACK exactly 1 cycle later with DBG_DATA = ROM[0x055]; IR, PC and FA unchanged; no second ACK while DBG_REQ drops at the ACK.
- Starvation: DBG_MAX_WAIT = 4, FETCH_EN = 1 continuously, DBG_REQ raised at t -> debug grant at t+4, DBG_ACK at t+5; exactly one IR_VALID gap (at t+5); the PC sequence is contiguous across the gap.
- Reset mid-operation: RST asserted in a debug-grant cycle -> no DBG_ACK next cycle; IR_VALID = 0, IR = 0; the first fetch after release is from RESET_ADDR.
